// File: rtl/bcd_count_sequencer_pkg.sv
// Shared types and constants for the BCD stopwatch/timer sequencer.
package bcd_seq_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  localparam int BCD_MAX = 9;
  localparam int DIGIT_W = 4;
endpackage

// File: rtl/bcd_count_sequencer_tick_prescaler.sv
// Divides the system clock down to one count tick every TICK_DIV running cycles.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic restart,
  output logic tick
);
  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // restart dominates so a command cycle never leaks a tick
  assign tick = run && !restart && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (restart) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/bcd_count_sequencer.sv
// Start/pause/resume/clear sequencer for a two-digit BCD counter, stopping at a
// programmable target; drives the counter's enable and clear inputs.
module bcd_count_sequencer
  import bcd_seq_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int NBITS    = DIGIT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_stop,
  input  logic             clear,
  input  logic [NBITS-1:0] target_u,
  input  logic [NBITS-1:0] target_d,
  input  logic [NBITS-1:0] counter_u,
  input  logic [NBITS-1:0] counter_d,
  output logic             cnt_enable,
  output logic             cnt_clear,
  output logic             running,
  output logic             done
);
  localparam logic [NBITS-1:0] DIGIT_MAX = NBITS'(BCD_MAX);

  function automatic logic [NBITS-1:0] clamp_digit(input logic [NBITS-1:0] d);
    return (d > DIGIT_MAX) ? DIGIT_MAX : d;
  endfunction

  seq_state_e r_state;
  logic       r_ss_prev;
  logic       r_clr_prev;
  logic       r_cmp_vld_p1;
  logic       r_cnt_enable;
  logic       r_cnt_clear;
  logic       r_running;
  logic       r_done;

  logic w_ss_cmd;
  logic w_clr_cmd;
  logic w_match;
  logic w_cmp_hit;
  logic w_run;
  logic w_restart;
  logic w_tick;

  assign w_ss_cmd  = start_stop & ~r_ss_prev;
  assign w_clr_cmd = clear & ~r_clr_prev;
  assign w_match   = (counter_u == clamp_digit(target_u)) &&
                     (counter_d == clamp_digit(target_d));
  // counter feedback is only trusted the cycle after an enable pulse
  assign w_cmp_hit = r_cmp_vld_p1 && w_match && ((r_state == RUN) || (r_state == PAUSE));
  assign w_run     = (r_state == RUN);
  assign w_restart = w_clr_cmd || (w_ss_cmd && ((r_state == IDLE) || (r_state == DONE)));

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .run    (w_run),
    .restart(w_restart),
    .tick   (w_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_ss_prev    <= 1'b1;
      r_clr_prev   <= 1'b1;
      r_cmp_vld_p1 <= 1'b0;
      r_cnt_enable <= 1'b0;
      r_cnt_clear  <= 1'b0;
      r_running    <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_ss_prev    <= start_stop;
      r_clr_prev   <= clear;
      r_cmp_vld_p1 <= r_cnt_enable;
      r_cnt_enable <= 1'b0;
      r_cnt_clear  <= 1'b0;
      if (w_clr_cmd) begin
        r_state     <= IDLE;
        r_cnt_clear <= 1'b1;
        r_running   <= 1'b0;
        r_done      <= 1'b0;
      end else if (w_cmp_hit) begin
        r_state   <= DONE;
        r_running <= 1'b0;
        r_done    <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_ss_cmd) begin
              r_state   <= RUN;
              r_running <= 1'b1;
            end
          end
          RUN: begin
            r_cnt_enable <= w_tick;
            if (w_ss_cmd) begin
              r_state   <= PAUSE;
              r_running <= 1'b0;
            end
          end
          PAUSE: begin
            if (w_ss_cmd) begin
              r_state   <= RUN;
              r_running <= 1'b1;
            end
          end
          DONE: begin
            if (w_ss_cmd) begin
              r_state     <= RUN;
              r_cnt_clear <= 1'b1;
              r_running   <= 1'b1;
              r_done      <= 1'b0;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign cnt_enable = r_cnt_enable;
  assign cnt_clear  = r_cnt_clear;
  assign running    = r_running;
  assign done       = r_done;
endmodule

// File: tb/tb_bcd_count_sequencer.sv
// Directed bench for bcd_count_sequencer with a BCD counter model in the loop and
// a cycle reference model checked on every falling edge.
module tb_bcd_count_sequencer;
  localparam int TD = 4;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] target_u = 4'd0;
  logic [3:0] target_d = 4'd0;
  logic [3:0] cu;
  logic [3:0] cd;
  logic       cnt_enable;
  logic       cnt_clear;
  logic       running;
  logic       done;

  logic       preset_req = 1'b0;
  logic [3:0] preset_u = 4'd0;
  logic [3:0] preset_d = 4'd0;

  int n_cmp = 0;
  int n_fail = 0;

  bcd_count_sequencer #(
    .TICK_DIV(TD),
    .NBITS   (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start_stop(start_stop),
    .clear     (clear),
    .target_u  (target_u),
    .target_d  (target_d),
    .counter_u (cu),
    .counter_d (cd),
    .cnt_enable(cnt_enable),
    .cnt_clear (cnt_clear),
    .running   (running),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Two-digit BCD counter the sequencer controls
  always @(posedge clk) begin
    if (reset) begin
      cu <= 4'd0;
      cd <= 4'd0;
    end else if (preset_req) begin
      cu <= preset_u;
      cd <= preset_d;
    end else if (cnt_clear) begin
      cu <= 4'd0;
      cd <= 4'd0;
    end else if (cnt_enable) begin
      if (cu == 4'd9) begin
        cu <= 4'd0;
        cd <= (cd == 4'd9) ? 4'd0 : cd + 4'd1;
      end else begin
        cu <= cu + 4'd1;
      end
    end
  end

  // Reference model: mode plus number of RUN cycles accumulated toward the next tick
  int m_mode = M_IDLE;
  int m_elapsed = 0;
  bit m_pss = 1'b1;
  bit m_pclr = 1'b1;
  bit m_en_prev = 1'b0;
  bit m_valid = 1'b0;
  bit e_en = 1'b0;
  bit e_clr = 1'b0;
  bit e_run = 1'b0;
  bit e_done = 1'b0;

  always @(posedge clk) begin
    bit ss;
    bit cl;
    bit cmp;
    bit hit;
    bit fire;
    logic [3:0] tu;
    logic [3:0] tdg;
    if (reset) begin
      m_mode = M_IDLE;
      m_elapsed = 0;
      m_pss = 1'b1;
      m_pclr = 1'b1;
      m_en_prev = 1'b0;
      e_en = 1'b0;
      e_clr = 1'b0;
      e_run = 1'b0;
      e_done = 1'b0;
      m_valid = 1'b1;
    end else begin
      ss = start_stop && !m_pss;
      cl = clear && !m_pclr;
      m_pss = start_stop;
      m_pclr = clear;
      cmp = m_en_prev;
      m_en_prev = e_en;
      tu = (target_u > 4'd9) ? 4'd9 : target_u;
      tdg = (target_d > 4'd9) ? 4'd9 : target_d;
      hit = (cu == tu) && (cd == tdg);
      fire = 1'b0;
      e_clr = 1'b0;
      if (cl) begin
        m_mode = M_IDLE;
        e_clr = 1'b1;
        m_elapsed = 0;
      end else if (cmp && hit && (m_mode == M_RUN || m_mode == M_PAUSE)) begin
        m_mode = M_DONE;
      end else begin
        case (m_mode)
          M_IDLE: if (ss) begin m_mode = M_RUN; m_elapsed = 0; end
          M_RUN: begin
            m_elapsed = m_elapsed + 1;
            if (m_elapsed == TD) begin fire = 1'b1; m_elapsed = 0; end
            if (ss) m_mode = M_PAUSE;
          end
          M_PAUSE: if (ss) m_mode = M_RUN;
          default: if (ss) begin m_mode = M_RUN; e_clr = 1'b1; m_elapsed = 0; end
        endcase
      end
      e_en = fire;
      e_run = (m_mode == M_RUN);
      e_done = (m_mode == M_DONE);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_cnt_enable", 32'(cnt_enable), 32'(e_en));
      check("model_cnt_clear", 32'(cnt_clear), 32'(e_clr));
      check("model_running", 32'(running), 32'(e_run));
      check("model_done", 32'(done), 32'(e_done));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic press(input bit do_ss, input bit do_clr);
    start_stop = do_ss;
    clear = do_clr;
    step();
    start_stop = 1'b0;
    clear = 1'b0;
  endtask

  task automatic preset(input logic [3:0] pd, input logic [3:0] pu);
    preset_d = pd;
    preset_u = pu;
    preset_req = 1'b1;
    step();
    preset_req = 1'b0;
  endtask

  initial begin
    int np;
    int pt[3];
    int first_done;
    int first_pulse;
    int cnt;

    // Reset state
    repeat (3) step();
    check("rst_cnt_enable", 32'(cnt_enable), 32'd0);
    check("rst_cnt_clear", 32'(cnt_clear), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    step();

    // 1: target 03 from 00
    target_u = 4'd3; target_d = 4'd0;
    press(1'b1, 1'b0);
    check("s1_running", 32'(running), 32'd1);
    np = 0; first_done = -1;
    pt[0] = 0; pt[1] = 0; pt[2] = 0;
    for (int t = 1; t <= 20; t++) begin
      step();
      if (cnt_enable === 1'b1) begin
        if (np < 3) pt[np] = t;
        np = np + 1;
      end
      if (done === 1'b1 && first_done < 0) first_done = t;
    end
    check("s1_npulses", 32'(np), 32'd3);
    check("s1_pulse0", 32'(pt[0]), 32'd4);
    check("s1_pulse1", 32'(pt[1]), 32'd8);
    check("s1_pulse2", 32'(pt[2]), 32'd12);
    check("s1_done_at", 32'(first_done), 32'd14);
    check("s1_count", {24'd0, cd, cu}, 32'h03);

    // 2: pause and resume
    press(1'b0, 1'b1);
    check("s2_clear_pulse", 32'(cnt_clear), 32'd1);
    step();
    target_u = 4'd5; target_d = 4'd0;
    press(1'b1, 1'b0);
    np = 0;
    for (int t = 1; t <= 6; t++) begin
      step();
      if (cnt_enable === 1'b1) np = np + 1;
      if (t == 5) check("s2_count01", {24'd0, cd, cu}, 32'h01);
    end
    check("s2_pre_pulses", 32'(np), 32'd1);
    press(1'b1, 1'b0);
    check("s2_paused", 32'(running), 32'd0);
    np = 0;
    for (int t = 1; t <= 10; t++) begin
      step();
      if (cnt_enable === 1'b1) np = np + 1;
    end
    check("s2_pause_pulses", 32'(np), 32'd0);
    press(1'b1, 1'b0);
    check("s2_resumed", 32'(running), 32'd1);
    check("s2_no_pulse_yet", 32'(cnt_enable), 32'd0);
    step();
    check("s2_pulse_after_resume", 32'(cnt_enable), 32'd1);
    step();
    check("s2_count02", {24'd0, cd, cu}, 32'h02);

    // 3: target 00 from 98
    press(1'b0, 1'b1);
    step();
    preset(4'd9, 4'd8);
    target_u = 4'd0; target_d = 4'd0;
    press(1'b1, 1'b0);
    check("s3_no_early_done", 32'(done), 32'd0);
    np = 0; first_done = -1;
    for (int t = 1; t <= 14; t++) begin
      step();
      if (cnt_enable === 1'b1) np = np + 1;
      if (done === 1'b1 && first_done < 0) first_done = t;
    end
    check("s3_npulses", 32'(np), 32'd2);
    check("s3_done_at", 32'(first_done), 32'd10);
    check("s3_count", {24'd0, cd, cu}, 32'h00);

    // 4: simultaneous clear and start_stop in RUN
    press(1'b0, 1'b1);
    step();
    target_u = 4'd9; target_d = 4'd0;
    press(1'b1, 1'b0);
    for (int t = 1; t <= 6; t++) step();
    check("s4_count01", {24'd0, cd, cu}, 32'h01);
    press(1'b1, 1'b1);
    check("s4_running", 32'(running), 32'd0);
    check("s4_clear", 32'(cnt_clear), 32'd1);
    cnt = 0;
    for (int t = 1; t <= 4; t++) begin
      step();
      if (cnt_clear === 1'b1) cnt = cnt + 1;
    end
    check("s4_extra_clears", 32'(cnt), 32'd0);
    check("s4_count", {24'd0, cd, cu}, 32'h00);

    // 5: restart from DONE, then clamped target FF
    target_u = 4'd1; target_d = 4'd0;
    press(1'b1, 1'b0);
    for (int t = 1; t <= 6; t++) step();
    check("s5_done", 32'(done), 32'd1);
    press(1'b1, 1'b0);
    check("s5_clear", 32'(cnt_clear), 32'd1);
    check("s5_running", 32'(running), 32'd1);
    check("s5_done_low", 32'(done), 32'd0);
    first_pulse = -1;
    for (int t = 1; t <= 6; t++) begin
      step();
      if (cnt_enable === 1'b1 && first_pulse < 0) first_pulse = t;
    end
    check("s5_first_pulse", 32'(first_pulse), 32'd4);
    check("s5_done_again", 32'(done), 32'd1);
    press(1'b0, 1'b1);
    step();
    preset(4'd9, 4'd7);
    target_u = 4'hF; target_d = 4'hF;
    press(1'b1, 1'b0);
    first_done = -1;
    for (int t = 1; t <= 14; t++) begin
      step();
      if (done === 1'b1 && first_done < 0) first_done = t;
    end
    check("s5_clamp_done_at", 32'(first_done), 32'd10);
    check("s5_clamp_count", {24'd0, cd, cu}, 32'h99);

    // 6: button held through reset; reset mid-RUN
    start_stop = 1'b1;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    cnt = 0;
    for (int t = 1; t <= 3; t++) begin
      step();
      if (running === 1'b1) cnt = cnt + 1;
    end
    check("s6_held_no_cmd", 32'(cnt), 32'd0);
    start_stop = 1'b0;
    step();
    target_u = 4'd9; target_d = 4'd9;
    press(1'b1, 1'b0);
    check("s6_running", 32'(running), 32'd1);
    for (int t = 1; t <= 3; t++) step();
    reset = 1'b1;
    step();
    check("s6_rst_cnt_enable", 32'(cnt_enable), 32'd0);
    check("s6_rst_running", 32'(running), 32'd0);
    check("s6_rst_done", 32'(done), 32'd0);
    check("s6_rst_cnt_clear", 32'(cnt_clear), 32'd0);
    reset = 1'b0;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
